// File: rtl/tpu_pkg.sv
// Shared types and default widths for the systolic array output path.
package tpu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_COLS   = 2;

    typedef logic [DEF_DATA_W-1:0] acc_t;
    typedef acc_t [DEF_COLS-1:0]   row_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } collect_state_t;

endpackage

// File: rtl/collector_fifo.sv
// Synchronous row FIFO with a per-entry last tag; wrap-bit pointers give full/empty.
module collector_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    input  logic         wr_last,
    output logic [W-1:0] rd_data,
    output logic         rd_last,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] last_mem;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             do_pop;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop = pop & ~empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_idx]      <= wr_data;
            last_mem[wr_idx] <= wr_last;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_idx];
    assign rd_last = ~empty & last_mem[rd_idx];

endmodule

// File: rtl/systolic_output_collector.sv
// Deskews bottom-row PE results, packs them into rows and buffers them for a valid/ready sink.
// Define COLLECT_RELU_EN to clamp negative column values to zero at push.
//
// state  | meaning
// IDLE   | no matrix partially drained
// ACTIVE | at least one row of the current matrix popped, last row still pending
module systolic_output_collector
    import tpu_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ROWS       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [COLS*DATA_W-1:0] acc_in,
    input  logic [COLS-1:0]        col_valid,
    output logic [COLS*DATA_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   done,
    output logic                   overflow,
    output logic                   skew_err
);

    localparam int ROW_W = COLS * DATA_W;
    localparam int CW    = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [COLS-1:0][DATA_W-1:0] col_d;
    logic [COLS-1:0]             col_v;
    logic [COLS-1:0][DATA_W-1:0] al_d;
    logic [COLS-1:0]             al_v;

    // Column j is delayed COLS-1-j cycles so every column lines up with the last one.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int D = COLS - 1 - j;
        if (D == 0) begin : g_direct
            assign col_d[j] = acc_in[j*DATA_W +: DATA_W];
            assign col_v[j] = col_valid[j];
        end else begin : g_delay
            logic [D-1:0][DATA_W-1:0] pd;
            logic [D-1:0]             pv;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pd <= '0;
                    pv <= '0;
                end else if (clear) begin
                    pd <= '0;
                    pv <= '0;
                end else begin
                    pd[0] <= acc_in[j*DATA_W +: DATA_W];
                    pv[0] <= col_valid[j];
                    for (int k = 1; k < D; k++) begin
                        pd[k] <= pd[k-1];
                        pv[k] <= pv[k-1];
                    end
                end
            end
            assign col_d[j] = pd[D-1];
            assign col_v[j] = pv[D-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            al_d <= '0;
            al_v <= '0;
        end else if (clear) begin
            al_d <= '0;
            al_v <= '0;
        end else begin
            al_d <= col_d;
            al_v <= col_v;
        end
    end

    logic             row_all;
    logic             row_any;
    logic             full;
    logic             empty;
    logic             pop_ok;
    logic             push_ok;
    logic             head_last;
    logic [ROW_W-1:0] push_data;
    logic [ROW_W-1:0] head_data;
    logic [CW-1:0]    push_cnt;
    collect_state_t   state;

    assign row_all = &al_v;
    assign row_any = |al_v;
    assign pop_ok  = out_ready & ~empty;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign push_ok = row_all & (~full | pop_ok);

    always_comb begin
        push_data = al_d;
`ifdef COLLECT_RELU_EN
        for (int j = 0; j < COLS; j++) begin
            if (al_d[j][DATA_W-1]) push_data[j*DATA_W +: DATA_W] = '0;
        end
`endif
    end

    collector_fifo #(
        .W     (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .push    (push_ok),
        .pop     (pop_ok),
        .wr_data (push_data),
        .wr_last (push_cnt == CW'(ROWS - 1)),
        .rd_data (head_data),
        .rd_last (head_last),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_cnt <= '0;
            overflow <= 1'b0;
            skew_err <= 1'b0;
            done     <= 1'b0;
            state    <= IDLE;
        end else if (clear) begin
            push_cnt <= '0;
            overflow <= 1'b0;
            skew_err <= 1'b0;
            done     <= 1'b0;
            state    <= IDLE;
        end else begin
            if (push_ok) push_cnt <= (push_cnt == CW'(ROWS - 1)) ? '0 : push_cnt + 1'b1;
            if (row_all && full && !pop_ok) overflow <= 1'b1;
            if (row_any && !row_all) skew_err <= 1'b1;
            done <= pop_ok & head_last;
            case (state)
                IDLE:    if (pop_ok && !head_last) state <= ACTIVE;
                ACTIVE:  if (pop_ok && head_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign out_data  = head_data;
    assign out_valid = ~empty;
    assign out_last  = head_last;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed bench for systolic_output_collector (COLS=2, DATA_W=8, ROWS=2, FIFO_DEPTH=4).
module tb_systolic_output_collector;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [15:0] acc_in;
    logic [1:0]  col_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        done;
    logic        overflow;
    logic        skew_err;

    int n_tests = 0;
    int n_fail  = 0;

    systolic_output_collector #(
        .COLS(2), .DATA_W(8), .ROWS(2), .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .acc_in    (acc_in),
        .col_valid (col_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done),
        .overflow  (overflow),
        .skew_err  (skew_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [1:0]  v;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_last;
        logic        e_done;
        logic        e_ovf;
        logic        e_skew;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic clr, input logic [1:0] v, input logic [7:0] d0,
                                input logic [7:0] d1, input logic rdy, input logic ev,
                                input logic [15:0] ed, input logic el, input logic edn,
                                input logic eo, input logic es);
        vec_t t;
        t.clr = clr; t.v = v; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
        t.e_valid = ev; t.e_data = ed; t.e_last = el; t.e_done = edn;
        t.e_ovf = eo; t.e_skew = es;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic rdy);
        col_valid = v;
        acc_in    = {d1, d0};
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(2'b00, 8'h00, 8'h00, 1'b0);
        clear = 1'b0;
    endtask

    function automatic logic [7:0] rd0(input int r);
        return 8'(16 * r + 1);
    endfunction

    function automatic logic [7:0] rd1(input int r);
        return 8'(16 * r + 2);
    endfunction

    // Streams n rows with col1 lagging col0 by one cycle; ready is high only in cycle pop_k.
    task automatic stream(input int n, input int pop_k);
        for (int k = 0; k <= n + 1; k++) begin
            logic [1:0] v;
            v[0] = (k < n);
            v[1] = (k >= 1) && (k <= n);
            cyc(v, rd0(k), rd1(k - 1), (k == pop_k));
        end
    endtask

    task automatic drain_check(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            int r;
            r = first + i;
            chk("drain_valid", 16'(out_valid), 16'h1);
            chk("drain_data", out_data, {rd1(r), rd0(r)});
            chk("drain_last", 16'(out_last), 16'((r % 2) == 1));
            cyc(2'b00, 8'h00, 8'h00, 1'b1);
            chk("drain_done", 16'(done), 16'((r % 2) == 1));
        end
        chk("drain_empty", 16'(out_valid), 16'h0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"}, 16'(out_valid), 16'h0);
        chk({name, "_data"}, out_data, 16'h0);
        chk({name, "_last"}, 16'(out_last), 16'h0);
        chk({name, "_done"}, 16'(done), 16'h0);
        chk({name, "_ovf"}, 16'(overflow), 16'h0);
        chk({name, "_skew"}, 16'(skew_err), 16'h0);
    endtask

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        acc_in    = '0;
        col_valid = '0;
        out_ready = 1'b0;

        tbl[0]  = mk(0, 2'b01, 8'h05, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 2'b10, 8'h00, 8'h07, 1, 0, 16'h0000, 0, 0, 0, 0);
        tbl[2]  = mk(0, 2'b00, 8'h00, 8'h00, 1, 1, 16'h0705, 0, 0, 0, 0);
        tbl[3]  = mk(0, 2'b00, 8'h00, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 0);
        tbl[4]  = mk(1, 2'b00, 8'h00, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0);
        tbl[5]  = mk(0, 2'b01, 8'h01, 8'h00, 0, 0, 16'h0000, 0, 0, 0, 0);
        tbl[6]  = mk(0, 2'b11, 8'h02, 8'h03, 0, 0, 16'h0000, 0, 0, 0, 0);
        tbl[7]  = mk(0, 2'b10, 8'h00, 8'h04, 0, 1, 16'h0301, 0, 0, 0, 0);
        tbl[8]  = mk(0, 2'b00, 8'h00, 8'h00, 0, 1, 16'h0301, 0, 0, 0, 0);
        tbl[9]  = mk(0, 2'b00, 8'h00, 8'h00, 1, 1, 16'h0402, 1, 0, 0, 0);
        tbl[10] = mk(0, 2'b00, 8'h00, 8'h00, 1, 0, 16'h0000, 0, 1, 0, 0);
        tbl[11] = mk(0, 2'b00, 8'h00, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 0);
        tbl[12] = mk(0, 2'b01, 8'h09, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 0);
        tbl[13] = mk(0, 2'b00, 8'h00, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 0);
        tbl[14] = mk(0, 2'b00, 8'h00, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 1);
        tbl[15] = mk(1, 2'b00, 8'h00, 8'h00, 1, 0, 16'h0000, 0, 0, 0, 0);

        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(2'b00, 8'h00, 8'h00, 1'b0);
        chk_all_zero("post_reset");

        // Skew removal, two-row matrix with done, aligned mismatch and clear.
        for (int i = 0; i < 16; i++) begin
            clear = tbl[i].clr;
            cyc(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].rdy);
            clear = 1'b0;
            chk($sformatf("vec%0d_valid", i), 16'(out_valid), 16'(tbl[i].e_valid));
            chk($sformatf("vec%0d_data", i), out_data, tbl[i].e_data);
            chk($sformatf("vec%0d_last", i), 16'(out_last), 16'(tbl[i].e_last));
            chk($sformatf("vec%0d_done", i), 16'(done), 16'(tbl[i].e_done));
            chk($sformatf("vec%0d_ovf", i), 16'(overflow), 16'(tbl[i].e_ovf));
            chk($sformatf("vec%0d_skew", i), 16'(skew_err), 16'(tbl[i].e_skew));
        end

        // Five rows into a depth-4 FIFO with no sink: the fifth is dropped.
        do_clear();
        stream(5, -1);
        cyc(2'b00, 8'h00, 8'h00, 1'b0);
        chk("ovf_set", 16'(overflow), 16'h1);
        chk("ovf_head", out_data, {rd1(0), rd0(0)});
        drain_check(0, 4);
        chk("ovf_sticky", 16'(overflow), 16'h1);

        // Full FIFO with push and pop on the same edge: no drop, order kept.
        do_clear();
        stream(5, 6);
        chk("simul_ovf", 16'(overflow), 16'h0);
        drain_check(1, 4);
        chk("simul_ovf_end", 16'(overflow), 16'h0);

        // Negative column handling at push.
        do_clear();
        cyc(2'b01, 8'h7F, 8'h00, 1'b0);
        cyc(2'b10, 8'h00, 8'h80, 1'b0);
        cyc(2'b00, 8'h00, 8'h00, 1'b0);
        chk("relu_valid", 16'(out_valid), 16'h1);
`ifdef COLLECT_RELU_EN
        chk("relu_data", out_data, 16'h007F);
`else
        chk("relu_data", out_data, 16'h807F);
`endif

        // Asynchronous reset with three rows buffered.
        do_clear();
        stream(3, -1);
        chk("prereset_valid", 16'(out_valid), 16'h1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(2'b00, 8'h00, 8'h00, 1'b1);
        chk_all_zero("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
